// File: rtl/fifo_pack_pkg.sv
// Shared constants and helpers for the FIFO read-side packer.
// Optional partial-word timeout flush is enabled by defining FIFO_PACK_TIMEOUT_EN.
package fifo_pack_pkg;

  localparam int unsigned DefWidth   = 8;
  localparam int unsigned DefLanes   = 4;
  localparam int unsigned DefTimeout = 16;
  localparam int unsigned MaxLanes   = 8;
  localparam int unsigned FillW      = $clog2(DefLanes) + 1;

  typedef logic [DefLanes-1:0] keep_t;

  // Fill counter must hold 0..lanes inclusive.
  function automatic int unsigned fill_w(input int unsigned lanes);
    return $clog2(lanes) + 1;
  endfunction

  function automatic logic [MaxLanes-1:0] keep_mask(input int unsigned n);
    logic [MaxLanes-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MaxLanes; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/fifo_pack_out_reg.sv
// Output holding register for packed words with a valid/ready handshake.
module fifo_pack_out_reg #(
  parameter int unsigned DataW = 32,
  parameter int unsigned KeepW = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [DataW-1:0] load_data_i,
  input  logic [KeepW-1:0] load_keep_i,
  input  logic             m_ready_i,
  output logic             slot_free_o,
  output logic             m_valid_o,
  output logic [DataW-1:0] m_data_o,
  output logic [KeepW-1:0] m_keep_o
);

  logic             valid_q;
  logic [DataW-1:0] data_q;
  logic [KeepW-1:0] keep_q;

  assign slot_free_o = !valid_q || m_ready_i;
  assign m_valid_o   = valid_q;
  assign m_data_o    = data_q;
  assign m_keep_o    = keep_q;

  // Callers only pulse load_i while the slot is free, so a load never overwrites a held word.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= load_data_i;
      keep_q  <= load_keep_i;
    end else if (m_ready_i) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_rd_packer.sv
// Drains an async FIFO on its read clock and packs LANES entries per output word.
// Define FIFO_PACK_TIMEOUT_EN to flush idle partial words after TIMEOUT cycles.
module fifo_rd_packer
  import fifo_pack_pkg::*;
#(
  parameter int unsigned WIDTH   = DefWidth,
  parameter int unsigned LANES   = DefLanes,
  parameter int unsigned TIMEOUT = DefTimeout
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   fifo_empty_i,
  input  logic [WIDTH-1:0]       fifo_rdata_i,
  output logic                   fifo_rd_en_o,
  output logic                   m_valid_o,
  input  logic                   m_ready_i,
  output logic [WIDTH*LANES-1:0] m_data_o,
  output logic [LANES-1:0]       m_keep_o
);

  localparam int unsigned FillBits = fill_w(LANES);

  logic [FillBits-1:0]          fill_q, fill_d, fill_cap;
  logic                         inflight_q;
  logic [LANES-1:0][WIDTH-1:0]  acc_q, acc_d;
  logic                         slot_free, load;
  logic [WIDTH*LANES-1:0]       load_data;
  logic [LANES-1:0]             load_keep;

  // Counting the in-flight read keeps the accumulator from being oversubscribed.
  assign fifo_rd_en_o = rst_ni && !fifo_empty_i &&
                        ((fill_q + FillBits'(inflight_q)) < FillBits'(LANES));

`ifdef FIFO_PACK_TIMEOUT_EN
  localparam int unsigned IdleW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [IdleW-1:0]    idle_q, idle_d;
  logic                idle_cond;
  logic [MaxLanes-1:0] mask;

  assign idle_cond = (fill_q != '0) && (fill_q < FillBits'(LANES)) && !inflight_q && fifo_empty_i;
  assign mask      = keep_mask(int'(fill_q));
`endif

  always_comb begin
    acc_d     = acc_q;
    fill_cap  = fill_q;
    load      = 1'b0;
    load_keep = '1;
    if (inflight_q) begin
      acc_d[fill_q[FillBits-2:0]] = fifo_rdata_i;
      fill_cap                    = fill_q + FillBits'(1);
    end
    load_data = acc_d;
    fill_d    = fill_cap;
    // A word completing on this edge goes straight to the output when the slot frees.
    if (fill_cap == FillBits'(LANES) && slot_free) begin
      load   = 1'b1;
      fill_d = '0;
      acc_d  = '0;
    end
`ifdef FIFO_PACK_TIMEOUT_EN
    idle_d = '0;
    if (idle_cond) begin
      if (idle_q == IdleW'(TIMEOUT - 1)) begin
        idle_d = idle_q;
        if (slot_free) begin
          load      = 1'b1;
          load_keep = mask[LANES-1:0];
          fill_d    = '0;
          acc_d     = '0;
          idle_d    = '0;
        end
      end else begin
        idle_d = idle_q + IdleW'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fill_q     <= '0;
      inflight_q <= 1'b0;
      acc_q      <= '0;
    end else begin
      fill_q     <= fill_d;
      inflight_q <= fifo_rd_en_o;
      acc_q      <= acc_d;
    end
  end

`ifdef FIFO_PACK_TIMEOUT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) idle_q <= '0;
    else         idle_q <= idle_d;
  end
`endif

  fifo_pack_out_reg #(
    .DataW (WIDTH * LANES),
    .KeepW (LANES)
  ) u_out_reg (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .load_i      (load),
    .load_data_i (load_data),
    .load_keep_i (load_keep),
    .m_ready_i   (m_ready_i),
    .slot_free_o (slot_free),
    .m_valid_o   (m_valid_o),
    .m_data_o    (m_data_o),
    .m_keep_o    (m_keep_o)
  );

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: queue-based FIFO model, word scoreboard, directed and random phases.
module tb_fifo_rd_packer;
  import fifo_pack_pkg::*;

  localparam int unsigned W = DefWidth;
  localparam int unsigned L = DefLanes;

  logic           clk_i = 1'b0;
  logic           rst_ni;
  logic           fifo_empty;
  logic [W-1:0]   fifo_rdata;
  logic           fifo_rd_en;
  logic           m_valid;
  logic           m_ready;
  logic [W*L-1:0] m_data;
  keep_t          m_keep;

  always #5 clk_i = ~clk_i;

  fifo_rd_packer #(
    .WIDTH   (W),
    .LANES   (L),
    .TIMEOUT (DefTimeout)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .fifo_empty_i (fifo_empty),
    .fifo_rdata_i (fifo_rdata),
    .fifo_rd_en_o (fifo_rd_en),
    .m_valid_o    (m_valid),
    .m_ready_i    (m_ready),
    .m_data_o     (m_data),
    .m_keep_o     (m_keep)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int words   = 0;
  int cyc     = 0;
  int rd_pulses;
  int acc_cyc[$];
  logic [W-1:0]   fifo_q[$];
  logic [W-1:0]   exp_q[$];
  logic           wr_en;
  logic [W-1:0]   wr_data;
  logic [W*L-1:0] last_data;
  keep_t          last_keep;
  logic           stall_prev;
  logic [W*L-1:0] prev_data;
  keep_t          prev_keep;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Source FIFO model: one-cycle read latency, empty flag registered after each edge.
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fifo_q.delete();
      fifo_empty <= 1'b1;
      fifo_rdata <= '0;
      rd_pulses  <= 0;
    end else begin
      if (fifo_rd_en && fifo_q.size() > 0) fifo_rdata <= fifo_q.pop_front();
      if (fifo_rd_en) rd_pulses <= rd_pulses + 1;
      if (wr_en) fifo_q.push_back(wr_data);
      fifo_empty <= (fifo_q.size() == 0);
    end
  end

  // Per-cycle monitor: read safety, stall stability, and word contents against written order.
  initial begin
    stall_prev = 1'b0;
    forever begin
      @(negedge clk_i);
      cyc++;
      if (!rst_ni) begin
        stall_prev = 1'b0;
      end else begin
        check("no_read_when_empty", 64'(fifo_rd_en & fifo_empty), 64'd0);
        if (stall_prev) begin
          check("stall_valid", 64'(m_valid), 64'd1);
          check("stall_data", 64'(m_data), 64'(prev_data));
          check("stall_keep", 64'(m_keep), 64'(prev_keep));
        end
        if (m_valid && m_ready) begin
          int n;
          logic [W*L-1:0] ed;
          keep_t ek;
`ifdef FIFO_PACK_TIMEOUT_EN
          n = $countones(m_keep);
          if (n == 0) n = 1;
`else
          n = L;
`endif
          ek = keep_t'((1 << n) - 1);
          ed = '0;
          for (int i = 0; i < n; i++) begin
            check("entry_available", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) ed[i*W +: W] = exp_q.pop_front();
          end
          check("word_keep", 64'(m_keep), 64'(ek));
          check("word_data", 64'(m_data), 64'(ed));
          last_data = m_data;
          last_keep = m_keep;
          acc_cyc.push_back(cyc);
          words++;
        end
        stall_prev = m_valid && !m_ready;
        prev_data  = m_data;
        prev_keep  = m_keep;
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic put(input logic [W-1:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    exp_q.push_back(d);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_words(input int target, input int budget, input string name);
    int n = 0;
    while (words < target && n < budget) begin
      tick();
      n++;
    end
    check(name, 64'(words), 64'(target));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, rp0, nwr, n;
    rst_ni  = 1'b0;
    m_ready = 1'b0;
    wr_en   = 1'b0;
    wr_data = '0;
    #12;
    check("reset_rd_en", 64'(fifo_rd_en), 64'd0);
    check("reset_valid", 64'(m_valid), 64'd0);
    check("reset_data", 64'(m_data), 64'd0);
    check("reset_keep", 64'(m_keep), 64'd0);
    tick();
    rst_ni = 1'b1;
    repeat (3) tick();

    // Single word from four entries
    m_ready = 1'b1;
    w0  = words;
    rp0 = rd_pulses;
    put(8'h11); put(8'h22); put(8'h33); put(8'h44);
    wait_words(w0 + 1, 40, "t1_word_count");
    repeat (10) tick();
    check("t1_read_pulses", 64'(rd_pulses - rp0), 64'd4);
    check("t1_data", 64'(last_data), 64'h44332211);
    check("t1_keep", 64'(last_keep), 64'hF);

    // Streaming: one word per LANES+1 clocks
    w0 = words;
    for (int i = 0; i < 16; i++) put(W'($urandom));
    wait_words(w0 + 4, 100, "t2_word_count");
    for (int k = 1; k < 4; k++)
      check("t2_word_period", 64'(acc_cyc[w0+k] - acc_cyc[w0+k-1]), 64'(L + 1));

    // Back-pressure: output word plus full accumulator, then reads stop
    m_ready = 1'b0;
    w0  = words;
    rp0 = rd_pulses;
    for (int i = 0; i < 16; i++) put(W'($urandom));
    repeat (24) tick();
    check("t3_reads_stalled", 64'(rd_pulses - rp0), 64'd8);
    check("t3_holding_valid", 64'(m_valid), 64'd1);
    m_ready = 1'b1;
    wait_words(w0 + 4, 100, "t3_word_count");

    // Six entries: partial word behaviour
    w0 = words;
    for (int i = 1; i <= 6; i++) put(W'(i));
    repeat (40) tick();
`ifdef FIFO_PACK_TIMEOUT_EN
    check("t4_words_after_idle", 64'(words - w0), 64'd2);
    check("t4_partial_keep", 64'(last_keep), 64'h3);
    check("t4_partial_data", 64'(last_data), 64'h00000605);
    put(8'h07); put(8'h08);
    repeat (40) tick();
    check("t4_words_total", 64'(words - w0), 64'd3);
    check("t4_tail_data", 64'(last_data), 64'h00000807);
`else
    check("t4_words_after_idle", 64'(words - w0), 64'd1);
    check("t4_partial_held", 64'(m_valid), 64'd0);
    put(8'h07); put(8'h08);
    wait_words(w0 + 2, 40, "t4_words_total");
    check("t4_tail_data", 64'(last_data), 64'h08070605);
    check("t4_tail_keep", 64'(last_keep), 64'hF);
`endif

    // Random traffic and back-pressure, then drain
    nwr = 0;
    for (int c = 0; c < 600; c++) begin
      m_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 1) == 1) begin
        wr_en   = 1'b1;
        wr_data = W'($urandom);
        exp_q.push_back(wr_data);
        nwr++;
      end else begin
        wr_en = 1'b0;
      end
      tick();
    end
    wr_en = 1'b0;
    while (nwr % L != 0) begin
      put(W'($urandom));
      nwr++;
    end
    m_ready = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || m_valid) && n < 300) begin
      tick();
      n++;
    end
    check("random_drain_left", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset mid-word, then restart at lane 0
    put(8'hA1); put(8'hA2);
    tick();
    #2;
    rst_ni = 1'b0;
    #1;
    check("rst_mid_rd_en", 64'(fifo_rd_en), 64'd0);
    check("rst_mid_valid", 64'(m_valid), 64'd0);
    check("rst_mid_data", 64'(m_data), 64'd0);
    check("rst_mid_keep", 64'(m_keep), 64'd0);
    exp_q.delete();
    repeat (3) tick();
    rst_ni = 1'b1;
    tick();
    w0 = words;
    put(8'hB1); put(8'hB2); put(8'hB3); put(8'hB4);
    wait_words(w0 + 1, 40, "rst_restart_count");
    check("rst_restart_data", 64'(last_data), 64'hB4B3B2B1);
    repeat (5) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_rd_packer.md
# fifo_rd_packer

Read-side drain stage placed directly downstream of the asynchronous FIFO, clocked by the FIFO's read clock. It issues FIFO reads whenever data is available and there is room, assembles LANES consecutive WIDTH-bit entries into one wide word, and presents that word on a valid/ready stream. It never reads an empty FIFO, so the FIFO's read-error flag stays deasserted in normal operation.

## Interface
- WIDTH, 8, bits per FIFO entry (matches FIFO data width)
- LANES, 4, entries packed per output word (power of two, 2..8)
- TIMEOUT, 16, idle cycles before a partial word is flushed (used only with FIFO_PACK_TIMEOUT_EN)
- clk_i  in  1  FIFO read clock
- rst_ni  in  1  asynchronous active-low reset
- fifo_empty_i  in  1  FIFO empty flag
- fifo_rdata_i  in  WIDTH  FIFO read data, valid the cycle after a read is issued
- fifo_rd_en_o  out  1  FIFO read enable
- m_valid_o  out  1  output word valid
- m_ready_i  in  1  downstream accepts word
- m_data_o  out  WIDTH*LANES  packed word, first entry in bits [WIDTH-1:0]
- m_keep_o  out  LANES  per-lane valid mask

## Operation
- Registered state: fill (0..LANES), inflight (1 bit, read issued last cycle), accumulator, output register (data, keep, valid).
- fifo_rd_en_o = rst_ni && !fifo_empty_i && (fill + inflight < LANES); combinational from registered state and fifo_empty_i.
- inflight <= fifo_rd_en_o each cycle.
- When inflight=1, fifo_rdata_i is written to lane `fill`; fill increments.
- Word completion (fill reaches LANES): if output slot free (!m_valid_o || m_ready_i), word moves to output register same edge, m_keep_o <= all ones, fill <= 0. Otherwise accumulator holds at fill=LANES; transfer occurs on the first edge the slot is free.
- Output handshake: word retired on edge with m_valid_o && m_ready_i. While m_valid_o && !m_ready_i, m_data_o/m_keep_o are held stable.
- Unused lanes of a partial word are zero.

## Timing
- Reset values: fifo_rd_en_o=0, m_valid_o=0, m_data_o=0, m_keep_o=0, fill=0, inflight=0.
- Read latency: entry issued at edge N is captured at edge N+1.
- First word: with FIFO non-empty and m_ready_i=1, m_valid_o rises LANES+1 cycles after first fifo_rd_en_o.
- Sustained throughput with continuous data and ready: one word per LANES+1 clocks (LANES reads, one bubble).
- Back-pressure: accumulator fills to LANES then reads stop; no entry is dropped or duplicated.
- fifo_empty_i asserting mid-word: reads pause, partial word retained; packing resumes in lane order.
- Reset mid-operation: accumulator, in-flight entry and output word discarded; FIFO is reset together with this block.

## Configuration
- FIFO_PACK_TIMEOUT_EN defined: idle counter counts cycles with 0<fill<LANES, inflight=0 and fifo_empty_i=1; cleared on any capture. On reaching TIMEOUT, when slot is free, partial word moves to output with m_keep_o set for lanes 0..fill-1, fill <= 0. Counter resets to 0.
- Not defined: partial words held indefinitely; m_keep_o is all ones whenever m_valid_o=1; no counter logic.

## Structure
- Package fifo_pack_pkg: default WIDTH/LANES/TIMEOUT constants, fill-count width constant ($clog2(LANES)+1), keep-mask type.
- One sub-module: fifo_pack_out_reg — output holding register with valid/ready, load strobe, and slot-free indication.

## Test plan
- Write 4 entries 0x11,0x22,0x33,0x44 into FIFO, m_ready_i=1 -> one word m_data_o=0x44332211, m_keep_o=0xF, exactly 4 read pulses.
- Write 16 entries, m_ready_i=1 -> 4 words in order, one word per 5 clocks once streaming, fifo_rd_en_o never high with fifo_empty_i=1, FIFO rd_error_o stays 0.
- Write 16 entries, m_ready_i=0 for 40 cycles then 1 -> m_data_o stable while stalled, reads stop after 8 entries (output + accumulator), all 4 words delivered afterwards without loss.
- Write 6 entries (macro off) -> one full word, remaining 2 held, m_valid_o stays 0 until 2 more written, then word 0x..(entries 5-8) with m_keep_o=0xF.
- Write 6 entries (FIFO_PACK_TIMEOUT_EN, TIMEOUT=16) -> second word emitted 16 idle cycles later with m_keep_o=0x3, upper lanes zero.
- Assert rst_ni low mid-word -> all outputs 0 asynchronously; after release with fresh FIFO data, packing restarts at lane 0.
